// File: rtl/async_fifo_pkg.sv
// Shared Gray-code helpers for the async FIFO pointer blocks (write and read side).
// Functions work on a 32-bit container; callers zero-extend and truncate to their width.
package async_fifo_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  // Binary to reflected Gray code; zero-extended upper bits stay zero.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary by a running XOR from the MSB down.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
    logic [GRAY_MAX_W-1:0] bin;
    bin = '0;
    bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // Full when the write Gray pointer equals the read Gray pointer with its top two bits inverted.
  function automatic logic full_compare(input logic [GRAY_MAX_W-1:0] wgray,
                                        input logic [GRAY_MAX_W-1:0] rgray,
                                        input int unsigned           width);
    logic [GRAY_MAX_W-1:0] mask;
    mask = GRAY_MAX_W'(2'b11) << (width - 2);
    return wgray == (rgray ^ mask);
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-stage flop chain bringing a Gray-coded bus into the local clock domain.
module sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  (* async_reg = "true", keep = "true" *) logic [WIDTH-1:0] sync_q [STAGES];

  // Plain shift chain, nothing combinational between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_wptr.sv
// Write-side pointer, RAM write address and full flag of an asynchronous FIFO.
// Optional almost-full output is built when ASYNC_FIFO_WPTR_AFULL_EN is defined.
module async_fifo_wptr
  import async_fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_gray,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
  output logic                  walmost_full,
`endif
  output logic                  wfull
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  // Reject configurations the pointer arithmetic cannot support.
  if (SYNC_STAGES < 2 || ADDR_WIDTH < 1 || AFULL_THRESH > 2 ** ADDR_WIDTH) begin : g_bad_cfg
    $error("async_fifo_wptr: illegal parameter combination");
  end

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          wfull_q, wfull_d;
  logic [PW-1:0] rq_gray;

  // Read pointer crossing into the write domain.
  sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rptr_gray),
    .q_o   (rq_gray)
  );

  assign wen = winc & ~wfull_q;

  // Next pointer, its Gray image and the full decision evaluated on that next pointer.
  always_comb begin
    wbin_d  = wbin_q + PW'(wen);
    wgray_d = PW'(bin2gray(GRAY_MAX_W'(wbin_d)));
    wfull_d = full_compare(GRAY_MAX_W'(wgray_d), GRAY_MAX_W'(rq_gray), PW);
  end

  // Pointer and flag registers; the Gray pointer leaving the domain is always a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  assign waddr     = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray = wgray_q;
  assign wfull     = wfull_q;

`ifdef ASYNC_FIFO_WPTR_AFULL_EN
  logic [PW-1:0] rq_bin;
  logic [PW-1:0] used_d;
  logic          afull_q, afull_d;

  // Occupancy seen from the write side, compared against the almost-full level.
  always_comb begin
    rq_bin  = PW'(gray2bin(GRAY_MAX_W'(rq_gray)));
    used_d  = wbin_d - rq_bin;
    afull_d = used_d >= PW'(2 ** ADDR_WIDTH - AFULL_THRESH);
  end

  // Almost-full register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      afull_q <= 1'b0;
    end else begin
      afull_q <= afull_d;
    end
  end

  assign walmost_full = afull_q;
`endif

endmodule

// File: tb/tb_async_fifo_wptr.sv
// Self-checking bench for async_fifo_wptr (ADDR_WIDTH=2, SYNC_STAGES=2, AFULL_THRESH=1).
// Reference model tracks writes and reads as plain counts; the read pointer view is delayed
// by the synchronizer depth. Define ASYNC_FIFO_WPTR_AFULL_EN to also cover walmost_full.
module tb_async_fifo_wptr;

  localparam int unsigned AW = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned AT = 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned PMOD  = 1 << (AW + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          winc;
  logic [AW:0]   rptr_gray;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          wfull;
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
  logic          walmost_full;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model state
  int unsigned m_wcnt;
  logic        m_full;
  logic        m_afull;
  int unsigned m_syn [SS];
  logic        obs_wen;
  logic        exp_wen;

  async_fifo_wptr #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (AT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .wen          (wen),
    .waddr        (waddr),
    .wptr_gray    (wptr_gray),
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
    .walmost_full (walmost_full),
`endif
    .wfull        (wfull)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int unsigned b);
    logic [AW:0] v;
    v = (AW+1)'(b % PMOD);
    return v ^ (v >> 1);
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    for (int i = 0; i < SS; i++) m_syn[i] = 0;
  endtask

  // One write-clock cycle: drive at the falling edge, update the model at the rising edge.
  task automatic cycle(input logic w, input int unsigned rd);
    int unsigned used;
    @(negedge clk);
    winc      = w;
    rptr_gray = to_gray(rd);
    #1;
    obs_wen = wen;
    exp_wen = w && !m_full;
    @(posedge clk);
    if (exp_wen) m_wcnt = (m_wcnt + 1) % PMOD;
    used    = (m_wcnt + PMOD - m_syn[SS-1]) % PMOD;
    m_full  = (used == DEPTH);
    m_afull = (used >= DEPTH - AT);
    for (int i = SS - 1; i > 0; i--) m_syn[i] = m_syn[i-1];
    m_syn[0] = rd % PMOD;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    winc = 1'b0;
    rptr_gray = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    winc = 1'b0;
    rptr_gray = '0;
    #3;
    checks++;
    if (wptr_gray !== '0 || waddr !== '0 || wfull !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: wptr_gray=%b waddr=%0d wfull=%b expected 0/0/0", wptr_gray, waddr, wfull);
    end
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
    checks++;
    if (walmost_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_afull: got %b expected 0", walmost_full);
    end
`endif
    apply_reset();
  endtask

  task automatic test_fill();
    logic [AW:0] exp_g [4];
    exp_g = '{3'b001, 3'b011, 3'b010, 3'b110};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 0);
      checks++;
      if (wptr_gray !== exp_g[i] || obs_wen !== 1'b1) begin
        failures++;
        $display("FAIL fill_step%0d: wptr_gray=%b wen=%b expected %b/1", i, wptr_gray, obs_wen, exp_g[i]);
      end
      checks++;
      if (wfull !== (i == 3)) begin
        failures++;
        $display("FAIL fill_full%0d: wfull=%b expected %b", i, wfull, (i == 3));
      end
    end
    cycle(1'b1, 0);
    checks++;
    if (wptr_gray !== 3'b110 || obs_wen !== 1'b0 || wfull !== 1'b1) begin
      failures++;
      $display("FAIL fill_blocked: wptr_gray=%b wen=%b wfull=%b expected 110/0/1", wptr_gray, obs_wen, wfull);
    end
  endtask

  task automatic test_release();
    for (int e = 1; e <= 3; e++) begin
      cycle(1'b0, 1);
      checks++;
      if (wfull !== (e < 3)) begin
        failures++;
        $display("FAIL release_edge%0d: wfull=%b expected %b", e, wfull, (e < 3));
      end
    end
    cycle(1'b1, 1);
    checks++;
    if (wptr_gray !== 3'b111 || obs_wen !== 1'b1) begin
      failures++;
      $display("FAIL release_write: wptr_gray=%b wen=%b expected 111/1", wptr_gray, obs_wen);
    end
  endtask

  task automatic test_wrap();
    logic [AW:0] prev_g;
    logic        saw_wrap;
    saw_wrap = 1'b0;
    prev_g   = wptr_gray;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, m_wcnt);
      checks++;
      if (wfull !== 1'b0 || waddr !== AW'((i + 1) % DEPTH) || wptr_gray !== to_gray(m_wcnt)) begin
        failures++;
        $display("FAIL wrap_step%0d: wfull=%b waddr=%0d wptr_gray=%b expected 0/%0d/%b",
                 i, wfull, waddr, wptr_gray, (i + 1) % DEPTH, to_gray(m_wcnt));
      end
      if (prev_g == 3'b100 && wptr_gray == 3'b000) saw_wrap = 1'b1;
      prev_g = wptr_gray;
    end
    checks++;
    if (saw_wrap !== 1'b1) begin
      failures++;
      $display("FAIL wrap_seen: saw 100->000 transition=%b expected 1", saw_wrap);
    end
  endtask

  task automatic test_simultaneous();
    repeat (3) cycle(1'b1, 0);
    cycle(1'b0, 1);
    cycle(1'b0, 1);
    cycle(1'b1, 1);
    checks++;
    if (obs_wen !== 1'b1 || wfull !== 1'b0 || wptr_gray !== 3'b110) begin
      failures++;
      $display("FAIL simul_same_edge: wen=%b wfull=%b wptr_gray=%b expected 1/0/110", obs_wen, wfull, wptr_gray);
    end
    cycle(1'b1, 1);
    checks++;
    if (obs_wen !== 1'b1 || wfull !== 1'b1 || wptr_gray !== 3'b111) begin
      failures++;
      $display("FAIL simul_then_full: wen=%b wfull=%b wptr_gray=%b expected 1/1/111", obs_wen, wfull, wptr_gray);
    end
  endtask

`ifdef ASYNC_FIFO_WPTR_AFULL_EN
  task automatic test_afull();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 0);
      checks++;
      if (walmost_full !== (i == 2) || wfull !== 1'b0) begin
        failures++;
        $display("FAIL afull_step%0d: walmost_full=%b wfull=%b expected %b/0", i, walmost_full, wfull, (i == 2));
      end
    end
  endtask
`endif

  task automatic test_random();
    int unsigned rd;
    rd = 0;
    for (int n = 0; n < 400; n++) begin
      if (rd != m_wcnt && ($urandom % 3) == 0) rd = (rd + 1) % PMOD;
      cycle(1'($urandom % 4 != 0), rd);
      checks++;
      if (obs_wen !== exp_wen || wptr_gray !== to_gray(m_wcnt) || waddr !== AW'(m_wcnt % DEPTH) ||
          wfull !== m_full) begin
        failures++;
        $display("FAIL random_cyc%0d: wen=%b wptr_gray=%b waddr=%0d wfull=%b expected %b/%b/%0d/%b",
                 n, obs_wen, wptr_gray, waddr, wfull, exp_wen, to_gray(m_wcnt), m_wcnt % DEPTH, m_full);
      end
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
      checks++;
      if (walmost_full !== m_afull) begin
        failures++;
        $display("FAIL random_afull%0d: walmost_full=%b expected %b", n, walmost_full, m_afull);
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) cycle(1'b1, 0);
    #2;
    rst_n = 1'b0;
    winc  = 1'b0;
    #1;
    checks++;
    if (wptr_gray !== '0 || waddr !== '0 || wfull !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_async: wptr_gray=%b waddr=%0d wfull=%b expected 0/0/0", wptr_gray, waddr, wfull);
    end
    @(posedge clk);
    #1;
    checks++;
    if (wptr_gray !== '0 || waddr !== '0 || wfull !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_hold: wptr_gray=%b waddr=%0d wfull=%b expected 0/0/0", wptr_gray, waddr, wfull);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 0);
    checks++;
    if (wptr_gray !== 3'b001 || waddr !== 2'd1) begin
      failures++;
      $display("FAIL reset_mid_resume: wptr_gray=%b waddr=%0d expected 001/1", wptr_gray, waddr);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_release();
    apply_reset();
    test_wrap();
    apply_reset();
    test_simultaneous();
`ifdef ASYNC_FIFO_WPTR_AFULL_EN
    apply_reset();
    test_afull();
`endif
    apply_reset();
    test_random();
    apply_reset();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
